cpu_trace_buffer: RTL and testbench
===================================

# cpu_trace_buffer

Execution trace capture stage that sits directly downstream of the 19-bit `cpu` core. It samples the core's debug outputs `pc_out`, `instruction_out` and `result_out` into a bounded on-chip buffer during a capture window. It then replays the captured entries oldest-first over a request/valid read port. Bring-up benches and the debug UART use it instead of printing `$display` lines every cycle.

## Interface
Parameters:
- `DEPTH`, 16, number of trace entries; power of two, at least 2.
- `ADDR_W`, 4, log2(`DEPTH`).

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `arm`  in  1  single-cycle pulse that starts a capture window.
- `stop`  in  1  single-cycle pulse that ends the capture window early.
- `valid_in`  in  1  the core sample on this cycle is valid (retired instruction).
- `pc_in`  in  19  from `cpu.pc_out`.
- `instr_in`  in  19  from `cpu.instruction_out`.
- `result_in`  in  19  from `cpu.result_out`.
- `rd_req`  in  1  pop the oldest entry.
- `rd_valid`  out  1  the `rd_*` data is valid; one-cycle pulse.
- `rd_pc`, `rd_instr`, `rd_result`  out  19 each  popped entry.
- `count`  out  ADDR_W+1  number of entries currently held.
- `full`  out  1  `count == DEPTH`.
- `overflow`  out  1  sticky; a sample was dropped.
- `state_out`  out  2  FSM state: 0 IDLE, 1 CAPTURE, 2 READOUT.

## Operation
- Storage is three `DEPTH`×19 arrays plus a write pointer, a read pointer and `count`.
- FSM transitions:
  - IDLE: an `arm` pulse clears the pointers, `count` and `overflow`, then moves to CAPTURE. `rd_req` is ignored.
  - CAPTURE: `valid_in` writes `{pc_in, instr_in, result_in}` at the write pointer, increments the write pointer (mod `DEPTH`) and increments `count`. A write that brings `count` to `DEPTH` moves to READOUT. A `stop` pulse moves to READOUT; a sample presented with `valid_in` on the same cycle is still written first. `arm` is ignored. `rd_req` is ignored.
  - READOUT: `rd_req` with `count > 0` registers the entry at the read pointer onto `rd_*` and pulses `rd_valid`. It also increments the read pointer and decrements `count`. When the pop that takes `count` from 1 to 0 completes, the FSM moves to IDLE on that same edge. `rd_req` with `count == 0` (only reachable by a `stop` before any sample) moves to IDLE without a pulse. Any `valid_in` in this state sets `overflow`. `arm` is ignored.
- In IDLE, `valid_in` is ignored and does not set `overflow`.
- Simultaneous `arm` and `stop` in IDLE: `arm` wins, and `stop` is ignored.
- `rd_*` outputs hold their last popped value between pulses.
- No arithmetic is performed on the data; entries are stored bit-exact.

## Timing
- Reset values:
  - `state_out` = 0
  - `count` = 0
  - `full` = 0
  - `overflow` = 0
  - `rd_valid` = 0
  - `rd_pc`, `rd_instr`, `rd_result` = 0
  - both pointers = 0
- Capture latency: a sample present at edge N is counted in `count` after edge N.
- Read latency: for `rd_req` high at edge N, `rd_valid` and the data are valid for one cycle after edge N. Back-to-back `rd_req` gives one entry per cycle.
- `full` and `count` are registered and update on the same edge as a write or pop.
- `overflow` is sticky until the next accepted `arm` or `reset`.
- Reset asserted mid-capture or mid-readout: buffer contents are discarded (`count` = 0) and the FSM returns to IDLE on that edge.

## Configuration
- `TRACE_DEDUP_EN`:
  - When defined, a CAPTURE-state sample whose `pc_in` equals the `pc_in` of the most recently written entry is not written and does not change `count`. This filters stalls and repeated fetches. The comparison register is invalidated on `arm` and on `reset`, so the first sample after `arm` is always written.
  - When undefined, every `valid_in` sample in CAPTURE is written.

## Test plan
- Reset, then `arm`, then 3 valid samples with pc 0, 1, 2 and instr 19'h00A01, 19'h00B02, 19'h00C03 -> `count` = 3, state CAPTURE. Then `stop` and 3 `rd_req` -> three `rd_valid` pulses returning pc 0, 1, 2 in order; state back to 0 after the third pop.
- `arm`, then 16 consecutive valid samples -> `full` = 1 after the 16th edge and state = 2. A 17th `valid_in` -> `overflow` = 1 and `count` stays 16.
- Fill 16 entries, pop 16 with back-to-back `rd_req` -> one entry per cycle, final `count` = 0, state IDLE. A further `rd_req` -> no `rd_valid`.
- `stop` on the same cycle as a valid sample with pc 7 -> that entry is stored, `count` increments, state = 2.
- `reset` asserted while `count` = 5 in CAPTURE -> next cycle `count` = 0, state 0, `overflow` 0, `rd_valid` 0.
- With `TRACE_DEDUP_EN` defined, samples with pc 4, 4, 4, 5 -> `count` = 2, reading back pc 4 then 5. Without the macro -> `count` = 4.

Source files
------------

// File: rtl/cpu_trace_buffer.sv
// Execution trace capture buffer for the 19-bit cpu core: captures pc/instr/result
// during an armed window and replays entries oldest-first. Optional macro: TRACE_DEDUP_EN.
module cpu_trace_buffer #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              arm,
  input  logic              stop,
  input  logic              valid_in,
  input  logic [18:0]       pc_in,
  input  logic [18:0]       instr_in,
  input  logic [18:0]       result_in,
  input  logic              rd_req,
  output logic              rd_valid,
  output logic [18:0]       rd_pc,
  output logic [18:0]       rd_instr,
  output logic [18:0]       rd_result,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              overflow,
  output logic [1:0]        state_out
);

  localparam int DATA_W = 19;
  localparam logic [ADDR_W:0]   COUNT_MAX = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   COUNT_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_READOUT = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [DATA_W-1:0] pc_mem     [DEPTH];
  logic [DATA_W-1:0] instr_mem  [DEPTH];
  logic [DATA_W-1:0] result_mem [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q;
  logic              overflow_q;
  logic              rd_valid_q;
  logic [DATA_W-1:0] rd_pc_q, rd_instr_q, rd_result_q;

  logic arm_go;
  logic wr_en;
  logic pop;
  logic ovf_set;
  logic dup_hit;

  // Qualified events; every state update below keys off these.
  assign arm_go  = (state_q == S_IDLE) && arm;
  assign wr_en   = (state_q == S_CAPTURE) && valid_in && !dup_hit;
  assign pop     = (state_q == S_READOUT) && rd_req && (count_q != '0);
  assign ovf_set = (state_q == S_READOUT) && valid_in;

`ifdef TRACE_DEDUP_EN
  // pc of the most recently written entry; invalid right after arm so the
  // first sample of a window is always kept.
  logic [DATA_W-1:0] last_pc_q;
  logic              last_pc_valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_pc_q       <= '0;
      last_pc_valid_q <= 1'b0;
    end else if (arm_go) begin
      last_pc_valid_q <= 1'b0;
    end else if (wr_en) begin
      last_pc_q       <= pc_in;
      last_pc_valid_q <= 1'b1;
    end
  end

  assign dup_hit = last_pc_valid_q && (pc_in == last_pc_q);
`else
  assign dup_hit = 1'b0;
`endif

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (arm_go) begin
      count_d = '0;
    end else if (wr_en) begin
      count_d = count_q + COUNT_ONE;
    end else if (pop) begin
      count_d = count_q - COUNT_ONE;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (arm) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        // A sample on the stop cycle is still written; the write happens regardless.
        if (stop || (wr_en && (count_q == COUNT_MAX - COUNT_ONE))) state_d = S_READOUT;
      end
      S_READOUT: begin
        // Covers both the final pop (1 -> 0) and a request on an empty buffer.
        if (rd_req && (count_q <= COUNT_ONE)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      overflow_q  <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_pc_q     <= '0;
      rd_instr_q  <= '0;
      rd_result_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      full_q  <= (count_d == COUNT_MAX);

      if (arm_go) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_ONE;
        if (pop)   rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end

      if (arm_go) begin
        overflow_q <= 1'b0;
      end else if (ovf_set) begin
        overflow_q <= 1'b1;
      end

      rd_valid_q <= pop;
      if (pop) begin
        rd_pc_q     <= pc_mem[rd_ptr_q];
        rd_instr_q  <= instr_mem[rd_ptr_q];
        rd_result_q <= result_mem[rd_ptr_q];
      end
    end
  end

  // NOTE: storage arrays are not reset; count and pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      pc_mem[wr_ptr_q]     <= pc_in;
      instr_mem[wr_ptr_q]  <= instr_in;
      result_mem[wr_ptr_q] <= result_in;
    end
  end

  assign rd_valid  = rd_valid_q;
  assign rd_pc     = rd_pc_q;
  assign rd_instr  = rd_instr_q;
  assign rd_result = rd_result_q;
  assign count     = count_q;
  assign full      = full_q;
  assign overflow  = overflow_q;
  assign state_out = state_q;

  a_count_bound: assert property (@(posedge clk) disable iff (reset) count_q <= COUNT_MAX);
  a_full_match:  assert property (@(posedge clk) disable iff (reset) full_q == (count_q == COUNT_MAX));
  a_legal_state: assert property (@(posedge clk) disable iff (reset) state_q != 2'd3);

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Directed self-checking bench for cpu_trace_buffer (DEPTH 16); expected values
// follow TRACE_DEDUP_EN when the macro is defined for the build.
module tb_cpu_trace_buffer;

  logic        clk;
  logic        reset;
  logic        arm;
  logic        stop;
  logic        valid_in;
  logic [18:0] pc_in;
  logic [18:0] instr_in;
  logic [18:0] result_in;
  logic        rd_req;
  logic        rd_valid;
  logic [18:0] rd_pc;
  logic [18:0] rd_instr;
  logic [18:0] rd_result;
  logic [4:0]  count;
  logic        full;
  logic        overflow;
  logic [1:0]  state_out;

  int tests_run    = 0;
  int tests_failed = 0;

  cpu_trace_buffer #(.DEPTH(16), .ADDR_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .arm       (arm),
    .stop      (stop),
    .valid_in  (valid_in),
    .pc_in     (pc_in),
    .instr_in  (instr_in),
    .result_in (result_in),
    .rd_req    (rd_req),
    .rd_valid  (rd_valid),
    .rd_pc     (rd_pc),
    .rd_instr  (rd_instr),
    .rd_result (rd_result),
    .count     (count),
    .full      (full),
    .overflow  (overflow),
    .state_out (state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 ns after the rising edge; outputs are read at the same point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    arm      = 1'b0;
    stop     = 1'b0;
    valid_in = 1'b0;
    rd_req   = 1'b0;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  task automatic push(input logic [18:0] pc, input logic [18:0] instr, input logic [18:0] res);
    valid_in  = 1'b1;
    pc_in     = pc;
    instr_in  = instr;
    result_in = res;
    step();
    valid_in  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rd_req = 1'b1;
    valid_in = 1'b1;
    step();
    step();
    if ({state_out, count, full, overflow, rd_valid} !== {2'd0, 5'd0, 3'b000}) begin
      $display("FAIL reset_status: state/count/full/ovf/vld got %0d/%0d/%b/%b/%b want 0/0/0/0/0",
               state_out, count, full, overflow, rd_valid);
      tests_failed++;
    end
    tests_run++;
    if ({rd_pc, rd_instr, rd_result} !== 57'd0) begin
      $display("FAIL reset_rd_data: got %h/%h/%h want 0/0/0", rd_pc, rd_instr, rd_result);
      tests_failed++;
    end
    tests_run++;
    reset = 1'b0;
    idle_inputs();
    step();
  endtask

  task automatic test_basic_capture();
    logic [18:0] instr_tab [3];
    instr_tab[0] = 19'h00A01;
    instr_tab[1] = 19'h00B02;
    instr_tab[2] = 19'h00C03;
    pulse_arm();
    if ({state_out, count} !== {2'd1, 5'd0}) begin
      $display("FAIL basic_armed: state/count got %0d/%0d want 1/0", state_out, count);
      tests_failed++;
    end
    tests_run++;
    for (int i = 0; i < 3; i++) push(19'(i), instr_tab[i], 19'(32'h30000 + i));
    if ({state_out, count, full} !== {2'd1, 5'd3, 1'b0}) begin
      $display("FAIL basic_captured: state/count/full got %0d/%0d/%b want 1/3/0", state_out, count, full);
      tests_failed++;
    end
    tests_run++;
    pulse_arm();
    if ({state_out, count} !== {2'd1, 5'd3}) begin
      $display("FAIL basic_arm_ignored: state/count got %0d/%0d want 1/3", state_out, count);
      tests_failed++;
    end
    tests_run++;
    stop = 1'b1;
    step();
    stop = 1'b0;
    if ({state_out, count} !== {2'd2, 5'd3}) begin
      $display("FAIL basic_stop: state/count got %0d/%0d want 2/3", state_out, count);
      tests_failed++;
    end
    tests_run++;
    rd_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      if ({rd_valid, rd_pc, rd_instr, rd_result} !== {1'b1, 19'(i), instr_tab[i], 19'(32'h30000 + i)}) begin
        $display("FAIL basic_pop%0d: vld/pc/instr/res got %b/%h/%h/%h want 1/%h/%h/%h", i,
                 rd_valid, rd_pc, rd_instr, rd_result, 19'(i), instr_tab[i], 19'(32'h30000 + i));
        tests_failed++;
      end
      tests_run++;
      if ({state_out, count} !== {(i < 2) ? 2'd2 : 2'd0, 5'(2 - i)}) begin
        $display("FAIL basic_pop%0d_status: state/count got %0d/%0d want %0d/%0d", i,
                 state_out, count, (i < 2) ? 2 : 0, 2 - i);
        tests_failed++;
      end
      tests_run++;
    end
    rd_req = 1'b0;
    step();
    if ({rd_valid, rd_pc, rd_instr} !== {1'b0, 19'd2, 19'h00C03}) begin
      $display("FAIL basic_hold: vld/pc/instr got %b/%h/%h want 0/2/00c03", rd_valid, rd_pc, rd_instr);
      tests_failed++;
    end
    tests_run++;
  endtask

  task automatic test_idle_and_empty();
    valid_in = 1'b1;
    rd_req   = 1'b1;
    stop     = 1'b1;
    pc_in    = 19'h7FFFF;
    step();
    step();
    if ({state_out, count, overflow, rd_valid} !== {2'd0, 5'd0, 2'b00}) begin
      $display("FAIL idle_ignores: state/count/ovf/vld got %0d/%0d/%b/%b want 0/0/0/0",
               state_out, count, overflow, rd_valid);
      tests_failed++;
    end
    tests_run++;
    idle_inputs();
    arm  = 1'b1;
    stop = 1'b1;
    step();
    idle_inputs();
    if (state_out !== 2'd1) begin
      $display("FAIL idle_arm_wins: state got %0d want 1", state_out);
      tests_failed++;
    end
    tests_run++;
    stop = 1'b1;
    step();
    stop = 1'b0;
    if ({state_out, count} !== {2'd2, 5'd0}) begin
      $display("FAIL empty_stop: state/count got %0d/%0d want 2/0", state_out, count);
      tests_failed++;
    end
    tests_run++;
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    if ({state_out, rd_valid} !== {2'd0, 1'b0}) begin
      $display("FAIL empty_rd_req: state/vld got %0d/%b want 0/0", state_out, rd_valid);
      tests_failed++;
    end
    tests_run++;
  endtask

  task automatic test_full_overflow();
    pulse_arm();
    for (int i = 0; i < 16; i++) begin
      push(19'(32'h100 + i), 19'(32'h50000 + i), 19'(32'h7FF00 - i));
      if (i == 14 && {state_out, count, full} !== {2'd1, 5'd15, 1'b0}) begin
        $display("FAIL full_at15: state/count/full got %0d/%0d/%b want 1/15/0", state_out, count, full);
        tests_failed++;
      end
      if (i == 14) tests_run++;
    end
    if ({state_out, count, full, overflow} !== {2'd2, 5'd16, 1'b1, 1'b0}) begin
      $display("FAIL full_at16: state/count/full/ovf got %0d/%0d/%b/%b want 2/16/1/0",
               state_out, count, full, overflow);
      tests_failed++;
    end
    tests_run++;
    push(19'h1FF, 19'h1FF, 19'h1FF);
    if ({state_out, count, full, overflow} !== {2'd2, 5'd16, 1'b1, 1'b1}) begin
      $display("FAIL overflow_17th: state/count/full/ovf got %0d/%0d/%b/%b want 2/16/1/1",
               state_out, count, full, overflow);
      tests_failed++;
    end
    tests_run++;
    rd_req = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      if ({rd_valid, rd_pc, rd_instr, rd_result} !==
          {1'b1, 19'(32'h100 + i), 19'(32'h50000 + i), 19'(32'h7FF00 - i)}) begin
        $display("FAIL b2b_pop%0d: vld/pc/instr/res got %b/%h/%h/%h want 1/%h/%h/%h", i,
                 rd_valid, rd_pc, rd_instr, rd_result,
                 19'(32'h100 + i), 19'(32'h50000 + i), 19'(32'h7FF00 - i));
        tests_failed++;
      end
      tests_run++;
      if (i == 0 && {count, full} !== {5'd15, 1'b0}) begin
        $display("FAIL b2b_first_pop_status: count/full got %0d/%b want 15/0", count, full);
        tests_failed++;
      end
      if (i == 0) tests_run++;
    end
    if ({state_out, count} !== {2'd0, 5'd0}) begin
      $display("FAIL b2b_drained: state/count got %0d/%0d want 0/0", state_out, count);
      tests_failed++;
    end
    tests_run++;
    step();
    rd_req = 1'b0;
    if ({rd_valid, state_out, overflow} !== {1'b0, 2'd0, 1'b1}) begin
      $display("FAIL b2b_extra_req: vld/state/ovf got %b/%0d/%b want 0/0/1", rd_valid, state_out, overflow);
      tests_failed++;
    end
    tests_run++;
    pulse_arm();
    if ({state_out, count, overflow} !== {2'd1, 5'd0, 1'b0}) begin
      $display("FAIL rearm_clears: state/count/ovf got %0d/%0d/%b want 1/0/0", state_out, count, overflow);
      tests_failed++;
    end
    tests_run++;
    stop = 1'b1;
    step();
    stop = 1'b0;
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
  endtask

  task automatic test_stop_with_valid();
    pulse_arm();
    push(19'h3, 19'h00D03, 19'h11111);
    stop = 1'b1;
    push(19'h7, 19'h00D07, 19'h12345);
    stop = 1'b0;
    if ({state_out, count} !== {2'd2, 5'd2}) begin
      $display("FAIL stop_valid_status: state/count got %0d/%0d want 2/2", state_out, count);
      tests_failed++;
    end
    tests_run++;
    rd_req = 1'b1;
    step();
    if ({rd_valid, rd_pc} !== {1'b1, 19'h3}) begin
      $display("FAIL stop_valid_pop0: vld/pc got %b/%h want 1/3", rd_valid, rd_pc);
      tests_failed++;
    end
    tests_run++;
    step();
    rd_req = 1'b0;
    if ({rd_valid, rd_pc, rd_instr, rd_result, state_out} !== {1'b1, 19'h7, 19'h00D07, 19'h12345, 2'd0}) begin
      $display("FAIL stop_valid_pop1: vld/pc/instr/res/state got %b/%h/%h/%h/%0d want 1/7/00d07/12345/0",
               rd_valid, rd_pc, rd_instr, rd_result, state_out);
      tests_failed++;
    end
    tests_run++;
  endtask

  task automatic test_reset_mid_run();
    pulse_arm();
    for (int i = 0; i < 5; i++) push(19'(32'h200 + i), 19'h0, 19'h0);
    if ({state_out, count} !== {2'd1, 5'd5}) begin
      $display("FAIL midreset_pre: state/count got %0d/%0d want 1/5", state_out, count);
      tests_failed++;
    end
    tests_run++;
    reset = 1'b1;
    step();
    reset = 1'b0;
    if ({state_out, count, full, overflow, rd_valid} !== {2'd0, 5'd0, 3'b000}) begin
      $display("FAIL midreset_capture: state/count/full/ovf/vld got %0d/%0d/%b/%b/%b want 0/0/0/0/0",
               state_out, count, full, overflow, rd_valid);
      tests_failed++;
    end
    tests_run++;
    pulse_arm();
    for (int i = 0; i < 16; i++) push(19'(32'h300 + i), 19'h1, 19'h2);
    push(19'h0, 19'h0, 19'h0);
    rd_req = 1'b1;
    step();
    if ({rd_valid, rd_pc, overflow, state_out} !== {1'b1, 19'h300, 1'b1, 2'd2}) begin
      $display("FAIL midreset_readout_pre: vld/pc/ovf/state got %b/%h/%b/%0d want 1/300/1/2",
               rd_valid, rd_pc, overflow, state_out);
      tests_failed++;
    end
    tests_run++;
    reset = 1'b1;
    step();
    reset = 1'b0;
    rd_req = 1'b0;
    if ({state_out, count, full, overflow, rd_valid, rd_pc} !== {2'd0, 5'd0, 3'b000, 19'h0}) begin
      $display("FAIL midreset_readout: state/count/full/ovf/vld/pc got %0d/%0d/%b/%b/%b/%h want 0/0/0/0/0/0",
               state_out, count, full, overflow, rd_valid, rd_pc);
      tests_failed++;
    end
    tests_run++;
  endtask

  task automatic test_dedup();
    logic [18:0] exp_pc    [4];
    logic [18:0] exp_instr [4];
    int          exp_n;
`ifdef TRACE_DEDUP_EN
    exp_n = 2;
    exp_pc[0] = 19'h4; exp_instr[0] = 19'h00001;
    exp_pc[1] = 19'h5; exp_instr[1] = 19'h00004;
    exp_pc[2] = 19'h0; exp_instr[2] = 19'h0;
    exp_pc[3] = 19'h0; exp_instr[3] = 19'h0;
`else
    exp_n = 4;
    exp_pc[0] = 19'h4; exp_instr[0] = 19'h00001;
    exp_pc[1] = 19'h4; exp_instr[1] = 19'h00002;
    exp_pc[2] = 19'h4; exp_instr[2] = 19'h00003;
    exp_pc[3] = 19'h5; exp_instr[3] = 19'h00004;
`endif
    pulse_arm();
    push(19'h4, 19'h00001, 19'h0);
    push(19'h4, 19'h00002, 19'h0);
    push(19'h4, 19'h00003, 19'h0);
    push(19'h5, 19'h00004, 19'h0);
    if (count !== 5'(exp_n)) begin
      $display("FAIL dedup_count: count got %0d want %0d", count, exp_n);
      tests_failed++;
    end
    tests_run++;
    stop = 1'b1;
    step();
    stop = 1'b0;
    rd_req = 1'b1;
    for (int i = 0; i < exp_n; i++) begin
      step();
      if ({rd_valid, rd_pc, rd_instr} !== {1'b1, exp_pc[i], exp_instr[i]}) begin
        $display("FAIL dedup_pop%0d: vld/pc/instr got %b/%h/%h want 1/%h/%h", i,
                 rd_valid, rd_pc, rd_instr, exp_pc[i], exp_instr[i]);
        tests_failed++;
      end
      tests_run++;
    end
    rd_req = 1'b0;
    if (state_out !== 2'd0) begin
      $display("FAIL dedup_drained: state got %0d want 0", state_out);
      tests_failed++;
    end
    tests_run++;
    // Same pc as the last entry of the previous window must still be kept.
    pulse_arm();
    push(19'h5, 19'h00010, 19'h0);
    push(19'h5, 19'h00011, 19'h0);
`ifdef TRACE_DEDUP_EN
    exp_n = 1;
`else
    exp_n = 2;
`endif
    if (count !== 5'(exp_n)) begin
      $display("FAIL dedup_rearm_count: count got %0d want %0d", count, exp_n);
      tests_failed++;
    end
    tests_run++;
    stop = 1'b1;
    step();
    stop = 1'b0;
    rd_req = 1'b1;
    for (int i = 0; i < 4 && state_out != 2'd0; i++) step();
    rd_req = 1'b0;
    if (state_out !== 2'd0) begin
      $display("FAIL dedup_rearm_drain: state got %0d want 0", state_out);
      tests_failed++;
    end
    tests_run++;
  endtask

  initial begin
    reset     = 1'b1;
    pc_in     = '0;
    instr_in  = '0;
    result_in = '0;
    idle_inputs();
    test_reset();
    test_basic_capture();
    idle_inputs();
    test_idle_and_empty();
    idle_inputs();
    test_full_overflow();
    idle_inputs();
    test_stop_with_valid();
    idle_inputs();
    test_reset_mid_run();
    idle_inputs();
    test_dedup();
    idle_inputs();
    step();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
